// File: rtl/mtimecmp_scheduler.sv
// rtl/mtimecmp_scheduler.sv - earliest-deadline multiplexer for mtimecmp (optional feature macro: MTIMECMP_SCHED_PERIODIC_EN)

module mtimecmp_scheduler #(
    parameter logic [31:0] SCHED_BASE_ADDR = 32'h4000_3000,
    parameter logic [31:0] TIMER_BASE_ADDR = 32'h4000_2000,
    parameter int          NUM_CH          = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              mem_we,
    input  logic              mem_re,
    output logic [31:0]       mem_rdata,
    input  logic [47:0]       mtime,
    output logic [31:0]       tmr_addr,
    output logic [31:0]       tmr_wdata,
    output logic              tmr_we,
    output logic [NUM_CH-1:0] ch_irq
);

    localparam logic [47:0] DL_MAX      = 48'hFFFF_FFFF_FFFF;
    localparam logic [1:0]  LAST_IDX    = 2'(NUM_CH - 1);
    localparam logic [2:0]  NCH         = 3'(NUM_CH);
    localparam logic [31:0] MTIMECMP_LO = TIMER_BASE_ADDR + 32'h8;
    localparam logic [31:0] MTIMECMP_HI = TIMER_BASE_ADDR + 32'hC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_WR_LO_MAX,
        S_WR_HI,
        S_WR_LO
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [47:0]       dl [NUM_CH];
    logic [NUM_CH-1:0] arm;
    logic [NUM_CH-1:0] fired;
    logic [NUM_CH-1:0] expire;
`ifdef MTIMECMP_SCHED_PERIODIC_EN
    logic [NUM_CH-1:0] periodic;
    logic [NUM_CH-1:0] reload;
    logic [31:0]       period [NUM_CH];
`endif

    logic              rescan_pending;
    logic              rescan_set;
    logic [1:0]        idx;
    logic [1:0]        sel_idx;
    logic              sel_valid;
    logic [47:0]       best;
    logic              scan_arm;
    logic [47:0]       scan_dl;

    logic              win_hit;
    logic              ch_hit;
    logic              status_hit;
    logic              cpu_wr;
    logic [1:0]        ch_sel;
    logic [1:0]        reg_sel;

    assign win_hit    = (mem_addr[31:7] == SCHED_BASE_ADDR[31:7]);
    assign ch_sel     = mem_addr[5:4];
    assign reg_sel    = mem_addr[3:2];
    assign ch_hit     = win_hit && (mem_addr[1:0] == 2'b00) && !mem_addr[6] && ({1'b0, ch_sel} < NCH);
    assign status_hit = win_hit && (mem_addr[6:0] == 7'h40);
    assign cpu_wr     = mem_we && ch_hit;
    assign rescan_set = (|expire) || cpu_wr;
    assign ch_irq     = fired;

    // Per-channel expiry against mtime; periodic channels with a non-zero period reload instead of disarming
    always_comb begin
        expire = '0;
`ifdef MTIMECMP_SCHED_PERIODIC_EN
        reload = '0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            expire[i] = arm[i] && (mtime >= dl[i]);
`ifdef MTIMECMP_SCHED_PERIODIC_EN
            reload[i] = periodic[i] && (period[i] != 32'd0);
`endif
        end
    end

    // Channel registers: expiry updates first, CPU writes override arm; a W1C never beats a new expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm   <= '0;
            fired <= '0;
`ifdef MTIMECMP_SCHED_PERIODIC_EN
            periodic <= '0;
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                dl[i] <= DL_MAX;
`ifdef MTIMECMP_SCHED_PERIODIC_EN
                period[i] <= 32'd0;
`endif
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (expire[i]) begin
                    fired[i] <= 1'b1;
`ifdef MTIMECMP_SCHED_PERIODIC_EN
                    if (reload[i]) begin
                        dl[i] <= dl[i] + {16'h0, period[i]};
                    end else begin
                        arm[i] <= 1'b0;
                    end
`else
                    arm[i] <= 1'b0;
`endif
                end
                if (cpu_wr && (ch_sel == 2'(i))) begin
                    case (reg_sel)
                        2'd0: dl[i][31:0]  <= mem_wdata;
                        2'd1: dl[i][47:32] <= mem_wdata[15:0];
                        2'd2: begin
                            arm[i] <= mem_wdata[0];
`ifdef MTIMECMP_SCHED_PERIODIC_EN
                            periodic[i] <= mem_wdata[1];
`endif
                            if (mem_wdata[8] && !expire[i]) begin
                                fired[i] <= 1'b0;
                            end
                        end
                        default: begin
`ifdef MTIMECMP_SCHED_PERIODIC_EN
                            period[i] <= mem_wdata;
`endif
                        end
                    endcase
                end
            end
        end
    end

    // Rescan request: a new trigger always wins over the clear taken by IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rescan_pending <= 1'b1;
        end else begin
            rescan_pending <= rescan_set || (rescan_pending && (state != S_IDLE));
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: scan NUM_CH channels, then the uninterruptible LO-max / HI / LO write triple
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (rescan_pending) state_next = S_SCAN;
            S_SCAN:      if (idx == LAST_IDX) state_next = S_WR_LO_MAX;
            S_WR_LO_MAX: state_next = S_WR_HI;
            S_WR_HI:     state_next = S_WR_LO;
            S_WR_LO:     state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Channel currently under scan
    always_comb begin
        scan_arm = 1'b0;
        scan_dl  = DL_MAX;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == 2'(i)) begin
                scan_arm = arm[i];
                scan_dl  = dl[i];
            end
        end
    end

    // Earliest-deadline search; strict compare keeps the lowest index on ties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= 2'd0;
            best      <= DL_MAX;
            sel_idx   <= 2'd0;
            sel_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rescan_pending) begin
                        idx       <= 2'd0;
                        best      <= DL_MAX;
                        sel_idx   <= 2'd0;
                        sel_valid <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (scan_arm && (scan_dl < best)) begin
                        best      <= scan_dl;
                        sel_idx   <= idx;
                        sel_valid <= 1'b1;
                    end
                    idx <= idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Registered timer write port, aligned with the write states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_we    <= 1'b0;
            tmr_addr  <= 32'd0;
            tmr_wdata <= 32'd0;
        end else begin
            tmr_we <= 1'b0;
            case (state_next)
                S_WR_LO_MAX: begin
                    tmr_we    <= 1'b1;
                    tmr_addr  <= MTIMECMP_LO;
                    tmr_wdata <= 32'hFFFF_FFFF;
                end
                S_WR_HI: begin
                    tmr_we    <= 1'b1;
                    tmr_addr  <= MTIMECMP_HI;
                    tmr_wdata <= {16'h0, best[47:32]};
                end
                S_WR_LO: begin
                    tmr_we    <= 1'b1;
                    tmr_addr  <= MTIMECMP_LO;
                    tmr_wdata <= best[31:0];
                end
                default: ;
            endcase
        end
    end

    // Combinational register read mux
    always_comb begin
        mem_rdata = 32'd0;
        if (mem_re) begin
            if (status_hit) begin
                mem_rdata = {26'd0, sel_idx, 2'b00, sel_valid, (state != S_IDLE)};
            end else if (ch_hit) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_sel == 2'(i)) begin
                        case (reg_sel)
                            2'd0: mem_rdata = dl[i][31:0];
                            2'd1: mem_rdata = {16'h0, dl[i][47:32]};
`ifdef MTIMECMP_SCHED_PERIODIC_EN
                            2'd2: mem_rdata = {23'd0, fired[i], 6'd0, periodic[i], arm[i]};
                            default: mem_rdata = period[i];
`else
                            2'd2: mem_rdata = {23'd0, fired[i], 6'd0, 1'b0, arm[i]};
                            default: mem_rdata = 32'd0;
`endif
                        endcase
                    end
                end
            end
        end
    end

endmodule
